sweep_counter: RTL and testbench

- Go-triggered run counter: on `go` it counts from a start value to a run-time limit, then pulses `done_sig` for one cycle.
- Parametrised successor of the fixed 4-bit up-counter FSM:
  - generic width;
  - run-time limit, latched per run;
  - up/down direction;
  - hold (pause) and abort;
  - optional completed-run statistics.
- Sits in the control path as a sequencer/timer for downstream blocks.

---
 rtl/sweep_counter_pkg.sv | 15 +
 rtl/sweep_counter.sv | 127 ++++++++++++
 tb/tb_sweep_counter.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/sweep_counter_pkg.sv
// Shared types and constants for the go-triggered sweep counter.
package sweep_counter_pkg;

    // Run sequencer states; encoding 2'd3 is illegal and recovers to IDLE.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Sweep direction as latched from the `down` input on an accepted go.
    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

endpackage

// File: rtl/sweep_counter.sv
// Go-triggered sweep counter: counts from a start value to a per-run latched
// limit (up or down), supports hold and abort, and pulses done_sig for one
// cycle when a run completes.
// Optional completed-run statistics (`passes`) are built when the macro
// SWEEP_COUNTER_STATUS_EN is defined.
module sweep_counter
    import sweep_counter_pkg::*;
#(
    parameter int WIDTH  = 4,
    parameter int PASS_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              go,
    input  logic [WIDTH-1:0]  limit,
    input  logic              down,
    input  logic              hold,
    input  logic              abort,
    output logic [WIDTH-1:0]  count,
    output logic              busy,
    output logic              done_sig
`ifdef SWEEP_COUNTER_STATUS_EN
    ,
    output logic [PASS_W-1:0] passes
`endif
);

    state_t             state_q;
    logic [WIDTH-1:0]   count_q;
    logic [WIDTH-1:0]   lim_q;
    logic               dir_q;
    logic               at_end;
    logic               run_complete;

    // First value shown in COUNT: 0 for an up sweep, the limit for a down sweep.
    function automatic logic [WIDTH-1:0] start_value(input logic dir,
                                                     input logic [WIDTH-1:0] lim);
        return (dir == DIR_DOWN) ? lim : '0;
    endfunction

    // Terminal value of the sweep: the limit going up, zero going down.
    function automatic logic [WIDTH-1:0] end_value(input logic dir,
                                                   input logic [WIDTH-1:0] lim);
        return (dir == DIR_DOWN) ? '0 : lim;
    endfunction

    // One step toward the terminal value, modulo 2^WIDTH.
    function automatic logic [WIDTH-1:0] step_count(input logic dir,
                                                    input logic [WIDTH-1:0] cnt);
        return (dir == DIR_DOWN) ? (cnt - WIDTH'(1)) : (cnt + WIDTH'(1));
    endfunction

    // Terminal detection and the COUNT->DONE event shared by FSM and statistics.
    always_comb begin
        at_end       = (count_q == end_value(dir_q, lim_q));
        run_complete = (state_q == COUNT) && !abort && !hold && at_end;
    end

    // Sequencer state, count datapath and per-run latched limit/direction.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            count_q <= '0;
            lim_q   <= '0;
            dir_q   <= DIR_UP;
        end else begin
            case (state_q)
                IDLE: begin
                    count_q <= '0;
                    if (go) begin
                        lim_q   <= limit;
                        dir_q   <= down;
                        count_q <= start_value(down, limit);
                        state_q <= COUNT;
                    end
                end
                COUNT: begin
                    if (abort) begin
                        count_q <= '0;
                        state_q <= IDLE;
                    end else if (!hold) begin
                        // The terminal value is always met before any wrap.
                        if (at_end) begin
                            state_q <= DONE;
                        end else begin
                            count_q <= step_count(dir_q, count_q);
                        end
                    end
                end
                DONE: begin
                    // Single-cycle pulse; go/hold/abort have no effect here.
                    count_q <= '0;
                    state_q <= IDLE;
                end
                default: begin
                    count_q <= '0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign count    = count_q;
    assign busy     = (state_q == COUNT);
    assign done_sig = (state_q == DONE);

`ifdef SWEEP_COUNTER_STATUS_EN
    logic [PASS_W-1:0] passes_q;

    // Saturating increment: sticks at all-ones instead of wrapping.
    function automatic logic [PASS_W-1:0] sat_inc(input logic [PASS_W-1:0] val);
        return (&val) ? val : (val + PASS_W'(1));
    endfunction

    // Completed-run counter; aborted runs never reach DONE and are not counted.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            passes_q <= '0;
        end else if (run_complete) begin
            passes_q <= sat_inc(passes_q);
        end
    end

    assign passes = passes_q;
`endif

endmodule

// File: tb/tb_sweep_counter.sv
// Self-checking bench for sweep_counter (WIDTH=4). Expected outputs are queued
// when inputs are driven and compared one cycle later, just after the edge.
// With SWEEP_COUNTER_STATUS_EN defined, pass statistics are also checked on a
// PASS_W=8 instance and a saturating PASS_W=2 instance.
module tb_sweep_counter;

    logic       clk = 1'b0;
    logic       rst_n, go, down, hold, abort;
    logic [3:0] limit;
    logic [3:0] count;
    logic       busy, done_sig;
`ifdef SWEEP_COUNTER_STATUS_EN
    logic [7:0] passes;
    logic [3:0] count2;
    logic       busy2, done2;
    logic [1:0] passes2;
`endif

    always #5 clk = ~clk;

    sweep_counter #(.WIDTH(4), .PASS_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .go(go), .limit(limit), .down(down),
        .hold(hold), .abort(abort), .count(count), .busy(busy),
        .done_sig(done_sig)
`ifdef SWEEP_COUNTER_STATUS_EN
        , .passes(passes)
`endif
    );

`ifdef SWEEP_COUNTER_STATUS_EN
    sweep_counter #(.WIDTH(4), .PASS_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .go(go), .limit(limit), .down(down),
        .hold(hold), .abort(abort), .count(count2), .busy(busy2),
        .done_sig(done2), .passes(passes2)
    );
`endif

    typedef struct {
        logic [3:0] c;
        logic       b;
        logic       d;
        logic [7:0] p;
        string      name;
    } exp_t;

    typedef struct {
        logic       rn, g, dn, h, ab;
        logic [3:0] lim;
        logic [3:0] ec;
        logic       eb, ed;
    } vec_t;

    exp_t sb[$];
    exp_t m;
    vec_t vt[21];
    int   n_cmp    = 0;
    int   n_fail   = 0;
    int   pass_exp = 0;

    // Drive one cycle of inputs on the falling edge and queue the outputs
    // expected after the following rising edge.
    task automatic cyc(input logic rn, input logic g, input logic dn,
                       input logic h, input logic ab, input logic [3:0] lim,
                       input logic [3:0] ec, input logic eb, input logic ed,
                       input string nm, input bit glitch = 1'b0);
        exp_t e;
        @(negedge clk);
        rst_n = rn; go = g; down = dn; hold = h; abort = ab; limit = lim;
        if (!rn) pass_exp = 0;
        else if (ed && pass_exp < 255) pass_exp++;
        e.c = ec; e.b = eb; e.d = ed; e.p = 8'(pass_exp); e.name = nm;
        sb.push_back(e);
        if (glitch) begin
            #1 rst_n = 1'b0;
            #1 rst_n = 1'b1;
        end
        @(posedge clk);
    endtask

    // Complete up run of the given limit starting from IDLE.
    task automatic short_run(input logic [3:0] lim);
        cyc(1, 1, 0, 0, 0, lim, 4'd0, 1, 0, "run_start");
        for (int k = 1; k <= int'(lim); k++)
            cyc(1, 0, 0, 0, 0, lim, 4'(k), 1, 0, "run_cnt");
        cyc(1, 0, 0, 0, 0, lim, lim, 0, 1, "run_done");
        cyc(1, 0, 0, 0, 0, lim, 4'd0, 0, 0, "run_idle");
    endtask

    // Scoreboard: pop one expectation per rising edge and compare after it.
    always @(posedge clk) begin
        #1;
        if (sb.size() > 0) begin
            m = sb.pop_front();
            n_cmp++;
            if (count !== m.c || busy !== m.b || done_sig !== m.d) begin
                n_fail++;
                $display("FAIL %s t=%0t: got count=%0d busy=%b done=%b, want count=%0d busy=%b done=%b",
                         m.name, $time, count, busy, done_sig, m.c, m.b, m.d);
            end
`ifdef SWEEP_COUNTER_STATUS_EN
            n_cmp++;
            if (passes !== m.p) begin
                n_fail++;
                $display("FAIL %s_passes t=%0t: got %0d, want %0d", m.name, $time, passes, m.p);
            end
            n_cmp++;
            if (passes2 !== ((m.p > 8'd3) ? 2'd3 : m.p[1:0])) begin
                n_fail++;
                $display("FAIL %s_passes_sat t=%0t: got %0d, want %0d", m.name, $time, passes2,
                         (m.p > 8'd3) ? 2'd3 : m.p[1:0]);
            end
`endif
        end
    end

    initial begin
        rst_n = 1'b0; go = 1'b0; down = 1'b0; hold = 1'b0; abort = 1'b0; limit = 4'd0;

        //          rn g  dn h  ab lim    ec     eb ed
        vt[0]  = '{0, 0, 0, 0, 0, 4'd0, 4'd0, 0, 0};  // reset state
        vt[1]  = '{1, 0, 0, 0, 0, 4'd0, 4'd0, 0, 0};  // idle holds 0
        vt[2]  = '{1, 1, 0, 0, 0, 4'd3, 4'd0, 1, 0};  // go up, limit 3
        vt[3]  = '{1, 0, 0, 0, 0, 4'd3, 4'd1, 1, 0};
        vt[4]  = '{1, 0, 0, 1, 0, 4'd3, 4'd1, 1, 0};  // hold one cycle
        vt[5]  = '{1, 0, 0, 0, 0, 4'd3, 4'd2, 1, 0};
        vt[6]  = '{1, 0, 0, 0, 0, 4'd3, 4'd3, 1, 0};
        vt[7]  = '{1, 0, 0, 0, 0, 4'd3, 4'd3, 0, 1};  // done, terminal shown
        vt[8]  = '{1, 1, 0, 1, 1, 4'd3, 4'd0, 0, 0};  // inputs ignored in DONE
        vt[9]  = '{1, 1, 1, 0, 0, 4'd0, 4'd0, 1, 0};  // limit 0 down
        vt[10] = '{1, 0, 1, 0, 0, 4'd0, 4'd0, 0, 1};
        vt[11] = '{1, 0, 0, 0, 0, 4'd0, 4'd0, 0, 0};
        vt[12] = '{1, 1, 1, 0, 0, 4'd2, 4'd2, 1, 0};  // down from 2
        vt[13] = '{1, 0, 1, 0, 1, 4'd2, 4'd0, 0, 0};  // abort
        vt[14] = '{1, 0, 0, 0, 0, 4'd2, 4'd0, 0, 0};
        vt[15] = '{1, 1, 1, 0, 0, 4'd2, 4'd2, 1, 0};
        vt[16] = '{1, 0, 1, 1, 1, 4'd2, 4'd0, 0, 0};  // abort beats hold
        vt[17] = '{1, 0, 0, 0, 0, 4'd0, 4'd0, 0, 0};
        vt[18] = '{1, 1, 0, 0, 0, 4'd0, 4'd0, 1, 0};  // limit 0 up
        vt[19] = '{1, 0, 0, 0, 0, 4'd0, 4'd0, 0, 1};
        vt[20] = '{1, 0, 0, 0, 0, 4'd0, 4'd0, 0, 0};

        for (int i = 0; i < 21; i++)
            cyc(vt[i].rn, vt[i].g, vt[i].dn, vt[i].h, vt[i].ab, vt[i].lim,
                vt[i].ec, vt[i].eb, vt[i].ed, $sformatf("vec%0d", i));

        // Full up sweep to 15: 16 busy cycles, then done with count 15.
        cyc(1, 1, 0, 0, 0, 4'd15, 4'd0, 1, 0, "up_start");
        for (int k = 1; k <= 15; k++)
            cyc(1, 0, 0, 0, 0, 4'd15, 4'(k), 1, 0, "up_cnt");
        cyc(1, 0, 0, 0, 0, 4'd15, 4'd15, 0, 1, "up_done");
        cyc(1, 0, 0, 0, 0, 4'd15, 4'd0, 0, 0, "up_idle");

        // Down sweep from 5; limit/direction inputs change mid-run.
        cyc(1, 1, 1, 0, 0, 4'd5, 4'd5, 1, 0, "dn_start");
        for (int k = 4; k >= 0; k--)
            cyc(1, 0, (k <= 2) ? 1'b0 : 1'b1, 0, 0, (k <= 2) ? 4'd9 : 4'd5,
                4'(k), 1, 0, "dn_cnt");
        cyc(1, 0, 0, 0, 0, 4'd9, 4'd0, 0, 1, "dn_done");
        cyc(1, 0, 0, 0, 0, 4'd9, 4'd0, 0, 0, "dn_idle");

        // Hold for 3 cycles at count 7 in an up run to 10.
        cyc(1, 1, 0, 0, 0, 4'd10, 4'd0, 1, 0, "hold_start");
        for (int k = 1; k <= 7; k++)
            cyc(1, 0, 0, 0, 0, 4'd10, 4'(k), 1, 0, "hold_cnt");
        for (int k = 0; k < 3; k++)
            cyc(1, 0, 0, 1, 0, 4'd10, 4'd7, 1, 0, "hold_frozen");
        for (int k = 8; k <= 10; k++)
            cyc(1, 0, 0, 0, 0, 4'd10, 4'(k), 1, 0, "hold_cnt2");
        cyc(1, 0, 0, 0, 0, 4'd10, 4'd10, 0, 1, "hold_done");
        cyc(1, 0, 0, 0, 0, 4'd10, 4'd0, 0, 0, "hold_idle");

        // Abort at count 4.
        cyc(1, 1, 0, 0, 0, 4'd8, 4'd0, 1, 0, "abort_start");
        for (int k = 1; k <= 4; k++)
            cyc(1, 0, 0, 0, 0, 4'd8, 4'(k), 1, 0, "abort_cnt");
        cyc(1, 0, 0, 0, 1, 4'd8, 4'd0, 0, 0, "abort_hit");
        cyc(1, 0, 0, 0, 0, 4'd8, 4'd0, 0, 0, "abort_idle");

        // go held high: exactly one IDLE cycle between back-to-back runs.
        cyc(1, 1, 0, 0, 0, 4'd2, 4'd0, 1, 0, "goh_r1");
        cyc(1, 1, 0, 0, 0, 4'd2, 4'd1, 1, 0, "goh_r1");
        cyc(1, 1, 0, 0, 0, 4'd2, 4'd2, 1, 0, "goh_r1");
        cyc(1, 1, 0, 0, 0, 4'd2, 4'd2, 0, 1, "goh_done1");
        cyc(1, 1, 0, 0, 0, 4'd2, 4'd0, 0, 0, "goh_gap");
        cyc(1, 1, 0, 0, 0, 4'd2, 4'd0, 1, 0, "goh_r2");
        cyc(1, 1, 0, 0, 0, 4'd2, 4'd1, 1, 0, "goh_r2");
        cyc(1, 1, 0, 0, 0, 4'd2, 4'd2, 1, 0, "goh_r2");
        cyc(1, 0, 0, 0, 0, 4'd2, 4'd2, 0, 1, "goh_done2");
        cyc(1, 0, 0, 0, 0, 4'd2, 4'd0, 0, 0, "goh_idle");

        // Reset: a glitch between edges is ignored; a low level at an edge
        // mid-run (count 9) returns everything to the reset state.
        cyc(1, 1, 0, 0, 0, 4'd12, 4'd0, 1, 0, "rst_start");
        for (int k = 1; k <= 9; k++)
            cyc(1, 0, 0, 0, 0, 4'd12, 4'(k), 1, 0, "rst_cnt", k == 3);
        cyc(0, 0, 0, 0, 0, 4'd12, 4'd0, 0, 0, "rst_mid");
        cyc(1, 0, 0, 0, 0, 4'd12, 4'd0, 0, 0, "rst_idle");

        // Statistics: 3 completed, 1 aborted, then 2 more completed runs.
        short_run(4'd1);
        short_run(4'd2);
        short_run(4'd1);
        cyc(1, 1, 0, 0, 0, 4'd2, 4'd0, 1, 0, "stat_abort_start");
        cyc(1, 0, 0, 0, 1, 4'd2, 4'd0, 0, 0, "stat_abort");
        short_run(4'd0);
        short_run(4'd0);

        repeat (3) @(posedge clk);
        #2;
        n_cmp++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending expectations, want 0", sb.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
